// File: rtl/test_pattern_sequencer.sv
// Steps the test pattern generator's pattern_sel at end of frame, auto or by button.
// Define PATTERN_SEQ_DEBOUNCE_EN to debounce the button for DEBOUNCE_CYC cycles.
module test_pattern_sequencer #(
  parameter int          H_ACTIVE     = 640,
  parameter int          V_ACTIVE     = 480,
  parameter int          DWELL_FRAMES = 120,
  parameter int          NUM_PATTERNS = 4,
  parameter int          INIT_PATTERN = 0,
  parameter logic [15:0] DEBOUNCE_CYC = 16'd50000
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        de,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        enable,
  input  logic        auto_mode,
  input  logic        btn_next,
  output logic [1:0]  pattern_sel_out,
  output logic        pattern_changed,
  output logic [15:0] frame_count
);

  localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);
  localparam logic [1:0] INIT = 2'(INIT_PATTERN);
  localparam logic [1:0] LAST = 2'(NUM_PATTERNS - 1);
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AUTO,
    S_MANUAL
  } state_t;

  state_t        state;
  logic [DW-1:0] dwell;
  logic          pending;
  logic          eof;
  logic [1:0]    nxt;
  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic          press;

  assign eof = de && (pixel_x == X_LAST) && (pixel_y == Y_LAST);
  assign nxt = (pattern_sel_out == LAST) ? 2'd0 : pattern_sel_out + 2'd1;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_next;
      sync2 <= sync1;
    end
  end

`ifdef PATTERN_SEQ_DEBOUNCE_EN
  logic [15:0] db_cnt;

  // level only follows sync2 after it has differed for DEBOUNCE_CYC cycles
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      level  <= 1'b0;
    end else if (sync2 == level) begin
      db_cnt <= '0;
    end else if (db_cnt == DEBOUNCE_CYC - 16'd1) begin
      db_cnt <= '0;
      level  <= sync2;
    end else begin
      db_cnt <= db_cnt + 16'd1;
    end
  end
`else
  logic unused_db;
  assign unused_db = ^DEBOUNCE_CYC;
  assign level = sync2;
`endif

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      pattern_sel_out <= INIT;
      pattern_changed <= 1'b0;
      frame_count     <= '0;
      dwell           <= '0;
      pending         <= 1'b0;
    end else begin
      pattern_changed <= 1'b0;
      if (eof) frame_count <= frame_count + 16'd1;
      unique case (state)
        S_IDLE: begin
          dwell   <= '0;
          pending <= 1'b0;
          if (eof) begin
            pattern_sel_out <= INIT;
            pattern_changed <= (pattern_sel_out != INIT);
          end
          if (enable) state <= auto_mode ? S_AUTO : S_MANUAL;
        end
        S_AUTO: begin
          if (eof) begin
            if (dwell == DWELL_LAST) begin
              dwell           <= '0;
              pattern_sel_out <= nxt;
              pattern_changed <= (nxt != pattern_sel_out);
            end else begin
              dwell <= dwell + DW'(1);
            end
          end
          // mode changes override any dwell update made this cycle
          if (!enable || !auto_mode) begin
            state   <= enable ? S_MANUAL : S_IDLE;
            dwell   <= '0;
            pending <= 1'b0;
          end
        end
        S_MANUAL: begin
          if (eof && (pending || press)) begin
            pattern_sel_out <= nxt;
            pattern_changed <= (nxt != pattern_sel_out);
            pending         <= 1'b0;
          end else if (press) begin
            pending <= 1'b1;
          end
          if (!enable || auto_mode) begin
            state   <= enable ? S_AUTO : S_IDLE;
            dwell   <= '0;
            pending <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_pattern_sequencer.sv
// Directed bench for test_pattern_sequencer on an 8x4 active / 10x5 total raster.
// Expected post-eof pattern values are queued per frame and popped on each eof.
module tb_test_pattern_sequencer;

  logic        pixel_clk = 1'b0;
  logic        rst_n;
  logic        de;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        enable;
  logic        auto_mode;
  logic        btn_next;
  logic [1:0]  pattern_sel_out;
  logic        pattern_changed;
  logic [15:0] frame_count;

  test_pattern_sequencer #(
    .H_ACTIVE     (8),
    .V_ACTIVE     (4),
    .DWELL_FRAMES (2),
    .NUM_PATTERNS (4),
    .INIT_PATTERN (0),
    .DEBOUNCE_CYC (16'd4)
  ) dut (
    .pixel_clk       (pixel_clk),
    .rst_n           (rst_n),
    .de              (de),
    .pixel_x         (pixel_x),
    .pixel_y         (pixel_y),
    .enable          (enable),
    .auto_mode       (auto_mode),
    .btn_next        (btn_next),
    .pattern_sel_out (pattern_sel_out),
    .pattern_changed (pattern_changed),
    .frame_count     (frame_count)
  );

  always #5 pixel_clk = ~pixel_clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         pulses  = 0;
  int         cx      = 0;
  int         cy      = 0;
  logic [1:0] exp_q[$];
  logic [1:0] last_sel;
  logic [15:0] fc_exp;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_pos();
    pixel_x = 10'(cx);
    pixel_y = 10'(cy);
    de      = (cx < 8) && (cy < 4);
  endtask

  task automatic step_pos();
    if (cx == 9) begin
      cx = 0;
      cy = (cy == 4) ? 0 : cy + 1;
    end else begin
      cx = cx + 1;
    end
    drive_pos();
  endtask

  task automatic tick();
    logic       was_eof;
    logic [1:0] e;
    was_eof = de && (cx == 7) && (cy == 3);
    @(posedge pixel_clk);
    #1;
    if (was_eof) begin
      fc_exp = fc_exp + 16'd1;
      if (exp_q.size() == 0) begin
        check("unexpected_eof", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sel_after_eof", 32'(pattern_sel_out), 32'(e));
        check("pulse_after_eof", 32'(pattern_changed), 32'(e != last_sel));
        check("frame_count", 32'(frame_count), 32'(fc_exp));
        last_sel = e;
      end
    end else begin
      check("sel_hold", 32'(pattern_sel_out), 32'(last_sel));
      check("no_pulse", 32'(pattern_changed), 32'd0);
    end
    if (pattern_changed) pulses++;
    step_pos();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic goto_pos(input int tx, input int ty);
    int budget;
    budget = 0;
    while (!(cx == tx && cy == ty) && budget < 100) begin
      tick();
      budget++;
    end
    check("goto_reached", 32'(cx == tx && cy == ty), 32'd1);
  endtask

  task automatic finish_frame();
    goto_pos(7, 3);
    tick();
  endtask

  task automatic frame(input logic [1:0] v);
    exp_q.push_back(v);
    finish_frame();
  endtask

  task automatic press_at(input int tx, input int ty, input int len);
    goto_pos(tx, ty);
    btn_next = 1'b1;
    ticks(len);
    btn_next = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    auto_mode = 1'b0;
    btn_next  = 1'b0;
    last_sel  = 2'd0;
    fc_exp    = 16'd0;
    drive_pos();
    repeat (2) @(posedge pixel_clk);
    #1;
    check("rst_sel", 32'(pattern_sel_out), 32'd0);
    check("rst_pulse", 32'(pattern_changed), 32'd0);
    check("rst_fc", 32'(frame_count), 32'd0);
    rst_n = 1'b1;

    // auto sequencing, dwell of two frames
    enable    = 1'b1;
    auto_mode = 1'b1;
    pulses    = 0;
    frame(2'd0); frame(2'd1); frame(2'd1); frame(2'd2); frame(2'd2);
    frame(2'd3); frame(2'd3); frame(2'd0); frame(2'd0);
    check("auto_pulses", 32'(pulses), 32'd4);
    check("auto_fc9", 32'(frame_count), 32'd9);

    // dwell is 1 here; a mode round trip must clear it
    exp_q.push_back(2'd0);
    goto_pos(2, 1);
    auto_mode = 1'b0;
    ticks(2);
    auto_mode = 1'b1;
    finish_frame();
    frame(2'd1);

    // manual: no press, single press, three presses in one frame
    auto_mode = 1'b0;
    frame(2'd1);
    exp_q.push_back(2'd2);
    press_at(1, 1, 5);
    finish_frame();
    exp_q.push_back(2'd3);
    goto_pos(0, 1);
    for (int i = 0; i < 3; i++) begin
      btn_next = 1'b1;
      ticks(2);
      btn_next = 1'b0;
      ticks(4);
    end
    finish_frame();
    frame(2'd3);

    // press event lands on eof itself, with wrap 3 -> 0
    exp_q.push_back(2'd0);
    press_at(4, 3, 2);
    finish_frame();
    frame(2'd0);
    // press event one cycle after eof waits a frame
    exp_q.push_back(2'd0);
    press_at(5, 3, 2);
    finish_frame();
    frame(2'd1);

    // reach 3, then disable mid-frame
    exp_q.push_back(2'd2);
    press_at(1, 1, 2);
    finish_frame();
    exp_q.push_back(2'd3);
    press_at(1, 1, 2);
    finish_frame();
    exp_q.push_back(2'd0);
    goto_pos(2, 1);
    enable = 1'b0;
    finish_frame();
    exp_q.push_back(2'd0);
    press_at(1, 1, 3);
    finish_frame();

    // short glitch, then a long press
    enable    = 1'b1;
    auto_mode = 1'b0;
`ifdef PATTERN_SEQ_DEBOUNCE_EN
    exp_q.push_back(2'd0);
`else
    exp_q.push_back(2'd1);
`endif
    press_at(1, 1, 3);
    finish_frame();
`ifdef PATTERN_SEQ_DEBOUNCE_EN
    exp_q.push_back(2'd1);
`else
    exp_q.push_back(2'd2);
`endif
    press_at(1, 1, 6);
    finish_frame();

    // async reset mid-frame; eof on the release edge is not counted
    goto_pos(3, 2);
    rst_n = 1'b0;
    #1;
    check("midrst_sel", 32'(pattern_sel_out), 32'd0);
    check("midrst_pulse", 32'(pattern_changed), 32'd0);
    check("midrst_fc", 32'(frame_count), 32'd0);
    cx = 7;
    cy = 3;
    drive_pos();
    @(posedge pixel_clk);
    #1;
    rst_n    = 1'b1;
    last_sel = 2'd0;
    fc_exp   = 16'd0;
    check("release_fc", 32'(frame_count), 32'd0);
    step_pos();
    frame(2'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
